// File: rtl/mux_cfg_pkg.sv
// Shared constants and helpers for the config-chain routing mux.
// Chain order and padding value live here so both files agree.
package mux_cfg_pkg;

    localparam logic CONST1_VAL = 1'b1;
    localparam bit   MSB_FIRST  = 1'b1;

    // Select width with a floor of one bit, so N_IN=2 still gets a select.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_tree_param.sv
// Binary tree of MUX2 cells; leaves beyond N_IN are tied to const1.
// Level 0 is the padded leaf row, level SEL_W is the root.
module mux_tree_param
    import mux_cfg_pkg::*;
#(
    parameter int N_IN = 45
) (
    input  logic [N_IN-1:0]            in,
    input  logic [sel_width(N_IN)-1:0] sel,
    output logic                       out
);

    localparam int SEL_W  = sel_width(N_IN);
    localparam int LEAVES = 1 << SEL_W;

    genvar lv, j;
    generate
        for (lv = 0; lv <= SEL_W; lv++) begin : g_lvl
            logic [(LEAVES >> lv)-1:0] v;
            if (lv == 0) begin : g_leaf
                for (j = 0; j < LEAVES; j++) begin : g_pad
                    if (j < N_IN) begin : g_in
                        assign v[j] = in[j];
                    end else begin : g_one
                        assign v[j] = CONST1_VAL;
                    end
                end
            end else begin : g_mux
                logic s;
                logic s_n;
                assign s   = sel[lv-1];
                assign s_n = ~s;
                for (j = 0; j < (LEAVES >> lv); j++) begin : g_cell
                    assign v[j] = (s   & g_lvl[lv-1].v[2*j+1])
                                | (s_n & g_lvl[lv-1].v[2*j]);
                end
            end
        end
    endgenerate

    // Output buffer stage (buf4).
    assign out = g_lvl[SEL_W].v[0];

endmodule

// File: rtl/mux_tree_cfgchain.sv
// Routing mux with serial config shadow register and explicit commit.
// Shifting only touches the shadow, so the datapath never glitches.
module mux_tree_cfgchain
    import mux_cfg_pkg::*;
#(
    parameter int                         N_IN      = 45,
    parameter logic [sel_width(N_IN)-1:0] RESET_SEL = '1,
    parameter int                         OUT_REG   = 0
) (
    input  logic                       prog_clk,
    input  logic                       pReset,
    input  logic [N_IN-1:0]            in,
    input  logic                       ccff_head,
    input  logic                       ccff_shift_en,
    output logic                       ccff_tail,
    input  logic                       cfg_commit,
    output logic                       out,
    output logic [sel_width(N_IN)-1:0] sel_active,
    output logic                       cfg_err
);

    localparam int SEL_W = sel_width(N_IN);
    localparam int CNT_W = $clog2(SEL_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SEL_W);

    logic [SEL_W-1:0] shadow_q, shadow_d;
    logic [SEL_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             err_q, err_d;

    logic [SEL_W-1:0] shifted;
    logic [CNT_W-1:0] cnt_base;
    logic             commit_ok;
    logic             out_c;

    assign commit_ok = cfg_commit & (bit_cnt_q == CNT_FULL);

    always_comb begin
        shifted = MSB_FIRST
            ? ((shadow_q << 1) | SEL_W'(ccff_head))
            : ((shadow_q >> 1) | (SEL_W'(ccff_head) << (SEL_W - 1)));
    end

    // Commit sees pre-shift shadow/count; a same-cycle shift then counts from 0.
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        err_d     = err_q | (cfg_commit & ~commit_ok);
        cnt_base  = commit_ok ? '0 : bit_cnt_q;
        bit_cnt_d = cnt_base;
        if (commit_ok) begin
            active_d = shadow_q;
        end
        if (ccff_shift_en) begin
            shadow_d = shifted;
            if (cnt_base != CNT_FULL) begin
                bit_cnt_d = cnt_base + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            shadow_q  <= '0;
            active_q  <= RESET_SEL;
            bit_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            bit_cnt_q <= bit_cnt_d;
            err_q     <= err_d;
        end
    end

    assign ccff_tail  = MSB_FIRST ? shadow_q[SEL_W-1] : shadow_q[0];
    assign sel_active = active_q;
    assign cfg_err    = err_q;

    mux_tree_param #(
        .N_IN (N_IN)
    ) u_tree (
        .in  (in),
        .sel (active_q),
        .out (out_c)
    );

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic out_q, out_d;
            always_comb out_d = out_c;
            always_ff @(posedge prog_clk or posedge pReset) begin
                if (pReset) begin
                    out_q <= CONST1_VAL;
                end else begin
                    out_q <= out_d;
                end
            end
            assign out = out_q;
        end else begin : g_comb
            assign out = out_c;
        end
    endgenerate

endmodule
